// File: rtl/regfile16.sv
// regfile16: 16 x DATA_W register file, one write port, two combinational read ports.
// R15 is hardwired to zero. Reset is asynchronous and active-high.
// Optional build macro: WRITE_BYPASS_EN -- forwards wr_data to a read port whose
// address matches the register being written in the same cycle (never for R15).
module regfile16 #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [3:0]        rd_addr_a,
    input  logic [3:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b
);

    // Only R0..R14 hold state; R15 is a constant zero source on the read side.
    logic [14:0][DATA_W-1:0] regs;
    logic [14:0]             wr_sel;
    logic [15:0][DATA_W-1:0] rd_src;

    // One-hot 4-to-16 write decode; the R15 line is simply not built.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < 15; i++) begin
            wr_sel[i] = wr_en && (wr_addr == 4'(i));
        end
    end

    // One register per row, each loaded only when its decode line is hot.
    for (genvar g = 0; g < 15; g++) begin : g_row
        // Row storage with async clear; reset wins over any pending write.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                regs[g] <= '0;
            end else if (wr_sel[g]) begin
                regs[g] <= wr_data;
            end
        end
    end

    // Read source table: 15 registers plus the zero row for R15.
    always_comb begin
        rd_src     = '0;
        rd_src[14:0] = regs;
    end

`ifdef WRITE_BYPASS_EN
    logic wr_live;
    assign wr_live = wr_en && !reset && (wr_addr != 4'hF);

    // 16:1 mux per port, overridden by in-flight write data on an address match.
    always_comb begin
        rd_data_a = rd_src[rd_addr_a];
        rd_data_b = rd_src[rd_addr_b];
        if (wr_live && (rd_addr_a == wr_addr)) rd_data_a = wr_data;
        if (wr_live && (rd_addr_b == wr_addr)) rd_data_b = wr_data;
    end
`else
    // 16:1 mux per port; a same-cycle write shows up only after the edge.
    always_comb begin
        rd_data_a = rd_src[rd_addr_a];
        rd_data_b = rd_src[rd_addr_b];
    end
`endif

endmodule

// File: tb/tb_regfile16.sv
// tb_regfile16: directed plus randomized checks of regfile16 against a simple
// array model. Honors WRITE_BYPASS_EN the same way the design does.
module tb_regfile16;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [3:0]    wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [3:0]    rd_addr_a = '0;
    logic [3:0]    rd_addr_b = '0;
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] rd_data_b;

    regfile16 #(.DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] model [16];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [3:0] a);
        if (reset) return '0;
        if (a == 4'hF) return '0;
`ifdef WRITE_BYPASS_EN
        if (wr_en && a == wr_addr) return wr_data;
`endif
        return model[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model[i] = '0;
    endtask

    // Drive one cycle: set inputs on the falling edge, check reads mid-low-phase,
    // then let the rising edge commit and mirror the write in the model.
    task automatic cycle(input logic we, input logic [3:0] wa, input logic [DW-1:0] wd,
                         input logic [3:0] ra, input logic [3:0] rb, input string tag);
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb;
        #2;
        check({tag, "_a"}, rd_data_a, exp_rd(ra));
        check({tag, "_b"}, rd_data_b, exp_rd(rb));
        @(posedge clk);
        if (we && !reset && wa != 4'hF) model[wa] = wd;
        #1;
    endtask

    initial begin
        logic [DW-1:0] pat;
        model_clear();

        // Reset held: every address reads 0 and writes are ignored.
        for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), 64'hFFFF_0000_FFFF_0000, 4'(i), 4'(15 - i), "rst_hold");
        @(negedge clk); reset = 1'b0; wr_en = 1'b0;

        // Post-reset: all 16 addresses zero on both ports.
        for (int i = 0; i < 16; i++) cycle(1'b0, 4'd0, '0, 4'(i), 4'(i), "post_rst");

        // Fill R0..R14 with 0x0101.. * i, then cross-read.
        pat = 64'h0101_0101_0101_0101;
        for (int i = 0; i < 15; i++) cycle(1'b1, 4'(i), pat * DW'(i), 4'(i), 4'(14 - i), "fill");
        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, 4'd0, '0, 4'(i), 4'(14 - i), "xread");
            check("xread_val", rd_data_a, pat * DW'(i));
        end

        // R15 ignores writes.
        cycle(1'b1, 4'hF, '1, 4'hF, 4'hF, "r15_wr");
        cycle(1'b0, 4'd0, '0, 4'hF, 4'hF, "r15_rd");
        check("r15_zero", rd_data_a, '0);

        // Same-cycle read of written address, then after edge.
        cycle(1'b1, 4'd5, 64'hDEAD_BEEF, 4'd5, 4'd5, "byp");
        cycle(1'b0, 4'd0, '0, 4'd5, 4'd4, "byp_after");
        check("byp_after_val", rd_data_a, 64'hDEAD_BEEF);

        // wr_en low for three edges leaves R3 alone.
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'd3, 64'h1234, 4'd3, 4'd3, "noen");
        check("noen_r3", rd_data_a, pat * 3);

        // Mid-cycle async reset cancels an in-flight write to R7.
        cycle(1'b1, 4'd7, 64'hA5A5, 4'd7, 4'd6, "r7_wr");
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 64'h5A5A; rd_addr_a = 4'd7; rd_addr_b = 4'd0;
        #1 reset = 1'b1; model_clear();
        #1 check("async_clr", rd_data_a, '0);
        @(posedge clk); #1;
        check("rst_edge", rd_data_a, '0);
        @(negedge clk); wr_en = 1'b0; reset = 1'b0;
        #2 check("rst_after", rd_data_a, '0);
        @(posedge clk); #1;
        // First write after reset is a normal write.
        cycle(1'b1, 4'd7, 64'h7777, 4'd7, 4'd7, "first_wr");
        cycle(1'b0, 4'd0, '0, 4'd7, 4'd7, "first_rd");
        check("first_val", rd_data_a, 64'h7777);

        // Randomized traffic with frequent address collisions.
        for (int n = 0; n < 400; n++) begin
            logic [3:0] wa, ra, rb;
            wa = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            rb = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
            cycle(1'($urandom_range(0, 1)), wa, {$urandom, $urandom}, ra, rb, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
